// File: rtl/rsp_xarb_if.sv
// Handshake bundle between response sources, targets and the crossbar matrix grant vectors.
interface rsp_xarb_if #(
    parameter int NS = 5,
    parameter int NT = 3,
    parameter int DW = 2
);
    logic [NS-1:0]    src_vld;
    logic [NS*DW-1:0] src_dst;
    logic [NS-1:0]    src_last;
    logic [NS-1:0]    src_rdy;
    logic [NT-1:0]    tgt_vld;
    logic [NT-1:0]    tgt_last;
    logic [NT-1:0]    tgt_rdy;
    logic [NS*NT-1:0] src_req;

    modport slave (
        input  src_vld, src_dst, src_last, tgt_rdy,
        output src_rdy, tgt_vld, tgt_last, src_req
    );

    modport master (
        output src_vld, src_dst, src_last, tgt_rdy,
        input  src_rdy, tgt_vld, tgt_last, src_req
    );
endinterface

// File: rtl/rsp_xarb.sv
// Response crossbar allocator: one round-robin owner FSM per target, grant held per packet.
// Optional macro RSP_XARB_B2B_EN: re-arbitrate in the release cycle (no idle gap between packets).
module rsp_xarb_tgt #(
    parameter int NS = 5,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [NS-1:0] cand,
    input  logic [NS-1:0] src_vld,
    input  logic [NS-1:0] src_last,
    input  logic          tgt_rdy,
    output logic [NS-1:0] gnt,
    output logic          tgt_vld,
    output logic          tgt_last
);
    typedef enum logic {IDLE, BUSY} state_t;
    localparam logic [AW:0] NS_W = (AW+1)'(NS);

    state_t        state;
    logic [AW-1:0] own, ptr, start, win, nxt;
    logic [AW:0]   idx;
    logic          found, rel, arb;

    assign rel = (state == BUSY) && src_vld[own] && tgt_rdy && src_last[own];
    assign nxt = (own == AW'(NS-1)) ? '0 : own + AW'(1);

`ifdef RSP_XARB_B2B_EN
    // releasing source is still flagged as an owner this cycle, so it is excluded from cand
    assign arb   = (state == IDLE) || rel;
    assign start = rel ? nxt : ptr;
`else
    assign arb   = (state == IDLE);
    assign start = ptr;
`endif

    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int i = 0; i < NS; i++) begin
            idx = {1'b0, start} + (AW+1)'(i);
            if (idx >= NS_W) idx = idx - NS_W;
            if (!found && cand[idx[AW-1:0]]) begin
                found = 1'b1;
                win   = idx[AW-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            own   <= '0;
            ptr   <= '0;
            gnt   <= '0;
        end else begin
            if (rel) begin
                state <= IDLE;
                ptr   <= nxt;
                gnt   <= '0;
            end
            if (arb && found) begin
                state <= BUSY;
                own   <= win;
                gnt   <= NS'(1) << win;
            end
        end
    end

    assign tgt_vld  = (state == BUSY) && src_vld[own];
    assign tgt_last = (state == BUSY) && src_last[own];
endmodule

module rsp_xarb #(
    parameter int NS = 5,
    parameter int NT = 3,
    parameter int DW = 2
) (
    input  logic        clk,
    input  logic        rst,
    rsp_xarb_if.slave   bus
);
    localparam int AW = (NS > 1) ? $clog2(NS) : 1;

    logic [NT-1:0][NS-1:0] gnt, cand;
    logic [NS-1:0]         owned, rdy;
    logic [NT-1:0]         tv, tl;
    logic [NS*NT-1:0]      req;

    // dst values >= NT match no target and are therefore never granted
    always_comb begin
        owned = '0;
        cand  = '0;
        for (int t = 0; t < NT; t++) owned = owned | gnt[t];
        for (int t = 0; t < NT; t++)
            for (int k = 0; k < NS; k++)
                cand[t][k] = bus.src_vld[k] && !owned[k] && (bus.src_dst[k*DW +: DW] == DW'(t));
    end

    generate
        for (genvar t = 0; t < NT; t++) begin : g_tgt
            rsp_xarb_tgt #(.NS(NS), .AW(AW)) u_tgt (
                .clk      (clk),
                .rst      (rst),
                .cand     (cand[t]),
                .src_vld  (bus.src_vld),
                .src_last (bus.src_last),
                .tgt_rdy  (bus.tgt_rdy[t]),
                .gnt      (gnt[t]),
                .tgt_vld  (tv[t]),
                .tgt_last (tl[t])
            );
        end
    endgenerate

    always_comb begin
        rdy = '0;
        req = '0;
        for (int t = 0; t < NT; t++)
            for (int k = 0; k < NS; k++) begin
                rdy[k]        = rdy[k] | (gnt[t][k] & bus.tgt_rdy[t]);
                req[k*NT + t] = gnt[t][k];
            end
    end

    assign bus.src_rdy  = rdy;
    assign bus.src_req  = req;
    assign bus.tgt_vld  = tv;
    assign bus.tgt_last = tl;
endmodule

// File: tb/tb_rsp_xarb.sv
// Directed bench for rsp_xarb: reset, single packet, contention, parallel routing, backpressure, abort.
module tb_rsp_xarb;
    logic clk, rst;
    int   n_chk = 0;
    int   n_err = 0;

    rsp_xarb_if #(.NS(5), .NT(3), .DW(2)) bus ();

    rsp_xarb #(.NS(5), .NT(3), .DW(2)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef RSP_XARB_B2B_EN
    localparam int C3N = 6;
    logic [4:0] v3 [0:C3N-1] = '{5'b10101, 5'b10101, 5'b10100, 5'b10001, 5'b00001, 5'b00000};
    logic [4:0] e3 [0:C3N-1] = '{5'b00000, 5'b00001, 5'b00100, 5'b10000, 5'b00001, 5'b00000};
`else
    localparam int C3N = 9;
    logic [4:0] v3 [0:C3N-1] = '{5'b10101, 5'b10101, 5'b10100, 5'b10100, 5'b10000,
                                 5'b10001, 5'b00001, 5'b00001, 5'b00000};
    logic [4:0] e3 [0:C3N-1] = '{5'b00000, 5'b00001, 5'b00000, 5'b00100, 5'b00000,
                                 5'b10000, 5'b00000, 5'b00001, 5'b00000};
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic set_dst(input int k, input int d);
        bus.src_dst[k*2 +: 2] = 2'(d);
    endtask

    initial begin
        rst          = 1'b1;
        bus.src_vld  = '0;
        bus.src_dst  = '0;
        bus.src_last = '0;
        bus.tgt_rdy  = '0;

        // reset then idle
        cyc(); cyc();
        chk("rst_req", 32'(bus.src_req), 'h0);
        chk("rst_rdy", 32'(bus.src_rdy), 'h0);
        chk("rst_tvld", 32'(bus.tgt_vld), 'h0);
        chk("rst_tlast", 32'(bus.tgt_last), 'h0);
        rst = 1'b0;
        cyc();
        chk("idle_req", 32'(bus.src_req), 'h0);
        chk("idle_tvld", 32'(bus.tgt_vld), 'h0);

        // single 3-beat packet, source 3 -> target 1
        bus.src_vld = 5'b01000; set_dst(3, 1); bus.tgt_rdy = 3'b111; #1;
        chk("t2_lat", 32'(bus.src_req), 'h0);
        cyc();
        chk("t2_req3", 32'(bus.src_req[9 +: 3]), 'b010);
        chk("t2_tvld", 32'(bus.tgt_vld), 'b010);
        chk("t2_rdy", 32'(bus.src_rdy), 'b01000);
        cyc();
        chk("t2_hold", 32'(bus.src_req[9 +: 3]), 'b010);
        cyc();
        bus.src_last = 5'b01000; #1;
        chk("t2_tlast", 32'(bus.tgt_last), 'b010);
        cyc();
        bus.src_vld = '0; bus.src_last = '0; #1;
        chk("t2_rel", 32'(bus.src_req), 'h0);

        // contention on target 0 from sources 0, 2, 4 with single-beat packets
        set_dst(0, 0); set_dst(2, 0); set_dst(4, 0);
        bus.src_last = 5'b10101;
        for (int i = 0; i < C3N; i++) begin
            bus.src_vld = v3[i]; #1;
            chk($sformatf("t3_rdy%0d", i), 32'(bus.src_rdy), 32'(e3[i]));
            chk($sformatf("t3_tvld%0d", i), 32'(bus.tgt_vld), {31'h0, |e3[i]});
            cyc();
        end
        bus.src_vld = '0; bus.src_last = '0;

        // parallel routing: source 1 -> target 0, source 3 -> target 2
        set_dst(1, 0); set_dst(3, 2);
        bus.src_vld = 5'b01010; #1;
        chk("t4_lat", 32'(bus.src_req), 'h0);
        cyc();
        chk("t4_req", 32'(bus.src_req), 'h0808);
        chk("t4_tvld", 32'(bus.tgt_vld), 'b101);
        bus.src_last = 5'b01010; #1;
        chk("t4_tlast", 32'(bus.tgt_last), 'b101);
        cyc();
        bus.src_vld = '0; bus.src_last = '0; #1;
        chk("t4_rel", 32'(bus.src_req), 'h0);

        // backpressure and bubble on target 2, owner source 4
        set_dst(4, 2);
        bus.src_vld = 5'b10000; bus.tgt_rdy = 3'b011;
        cyc();
        chk("t5_req4", 32'(bus.src_req[12 +: 3]), 'b100);
        chk("t5_tvld", 32'(bus.tgt_vld), 'b100);
        chk("t5_rdy0", 32'(bus.src_rdy), 'h0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk($sformatf("t5_bp%0d", i), 32'(bus.src_req[12 +: 3]), 'b100);
            chk($sformatf("t5_bprdy%0d", i), 32'(bus.src_rdy), 'h0);
        end
        bus.tgt_rdy = 3'b111; #1;
        chk("t5_rdy1", 32'(bus.src_rdy), 'b10000);
        cyc();
        bus.src_vld = '0; set_dst(4, 0); #1;
        chk("t5_bub", 32'(bus.tgt_vld), 'h0);
        cyc();
        chk("t5_bubhold", 32'(bus.src_req), 'h4000);
        bus.src_vld = 5'b10000; bus.src_last = 5'b10000; #1;
        chk("t5_dstign", 32'(bus.tgt_vld), 'b100);
        chk("t5_tlast", 32'(bus.tgt_last), 'b100);
        cyc();
        bus.src_vld = '0; bus.src_last = '0; #1;
        chk("t5_rel", 32'(bus.src_req), 'h0);

        // out-of-range destination is never granted
        set_dst(2, 3);
        bus.src_vld = 5'b00100;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk($sformatf("t6_oor_req%0d", i), 32'(bus.src_req), 'h0);
            chk($sformatf("t6_oor_rdy%0d", i), 32'(bus.src_rdy), 'h0);
        end
        bus.src_vld = '0;

        // reset mid-packet on target 1 (pointer there is 4 before reset)
        set_dst(0, 1);
        bus.src_vld = 5'b00001;
        cyc();
        chk("t6_req0", 32'(bus.src_req[0 +: 3]), 'b010);
        cyc();
        rst = 1'b1; #1;
        chk("t6_arst_req", 32'(bus.src_req), 'h0);
        chk("t6_arst_rdy", 32'(bus.src_rdy), 'h0);
        chk("t6_arst_tvld", 32'(bus.tgt_vld), 'h0);
        bus.src_vld = '0;
        cyc();
        rst = 1'b0;
        set_dst(1, 1); set_dst(4, 1);
        bus.src_vld = 5'b10010; #1;
        chk("t6_post_lat", 32'(bus.src_req), 'h0);
        cyc();
        chk("t6_ptr0", 32'(bus.src_req), 'h0010);
        chk("t6_ptr0rdy", 32'(bus.src_rdy), 'b00010);
        bus.src_vld = '0;
        cyc();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/rsp_xarb.md
Name: rsp_xarb

Overview:
Response-side allocator that drives the per-source grant vectors of the response crossbar matrix. It arbitrates packets from NS response sources onto NT targets, one round-robin arbiter per target, and holds each grant for a whole packet until the handshake on its last beat. Its grant outputs are onehot0 per source and never duplicated across sources, which is exactly what the matrix requires. It also steers valid/ready between each granted source and its target.

Parameters:
NS, 5, number of response sources (matrix rows I0..I4)
NT, 3, number of targets (matrix columns T0..T2)
DW, 2, width of each source's target-index field; must satisfy 2**DW >= NT

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, asynchronous, active-high
src_vld  in  NS  per-source valid
src_dst  in  NS*DW  per-source target index; slice k = bits [k*DW +: DW]
src_last  in  NS  per-source last beat of packet
src_rdy  out  NS  per-source ready
tgt_vld  out  NT  per-target valid
tgt_last  out  NT  per-target last, taken from the owning source
tgt_rdy  in  NT  per-target ready
src_req  out  NS*NT  grant vectors; slice k = Ik_req to the matrix; bit t set means source k is routed to target t

Behaviour:
- Reset (asynchronous, active-high): all of the following hold while rst=1.
  - src_req=0, src_rdy=0, tgt_vld=0, tgt_last=0.
  - All target FSMs go to IDLE.
  - All round-robin pointers go to 0.
- One FSM per target t, with states IDLE and BUSY, and a registered owner index own[t].
- Eligibility:
  - Source k is a candidate for t when src_vld[k]=1, src_dst slice k == t, and k is not currently owner of any target.
  - A src_dst value >= NT is never granted. That source sees src_rdy=0 forever (no error flag).
- IDLE:
  - Round-robin search over the candidates, starting at ptr[t] and wrapping NS-1 -> 0.
  - On a winner w: next cycle BUSY, own[t]=w, src_req bit (w,t)=1.
  - The grant is registered, so arbitration latency is 1 cycle from src_vld to src_req/tgt_vld.
- BUSY (all combinational from registered own[t]):
  - tgt_vld[t] = src_vld[own].
  - tgt_last[t] = src_last[own].
  - src_rdy[own] = tgt_rdy[t].
- Release: on src_vld[own] & tgt_rdy[t] & src_last[own], the next state is IDLE.
  - ptr[t] becomes own+1, wrapping to 0 when own+1 == NS.
  - The src_req bit clears on the same edge.
- Targets arbitrate independently in the same cycle. A source appears as a candidate at most once, because it has only one dst, so src_req never has two bits set in one source slice.
- Each target has at most one owner, so no two source slices share a bit. Both matrix preconditions therefore hold by construction.
- src_vld deasserted mid-packet: the grant is held, and tgt_vld follows src_vld (bubble).
- src_dst changing mid-packet is ignored; routing stays with own[t] until last.
- Single-beat packet (src_last=1 on the first beat) is legal and releases on that beat.
- Outputs of an unowned target: tgt_vld=0, tgt_last=0.
- Sources that are not owners: src_rdy=0.
- Reset mid-packet aborts the packet. No residual grant survives the reset.

Optional Feature:
RSP_XARB_B2B_EN
- Defined: in the release cycle the target re-arbitrates immediately, using the post-release pointer and excluding the releasing source for that cycle. A new grant is registered on the same edge, giving no idle cycle between packets.
- Undefined: after release the target spends at least one cycle in IDLE, so there is a minimum 1-cycle gap between packets on a target.

Test Plan:
1. Reset then idle: rst pulse with src_vld=0 -> src_req=0, src_rdy=0, tgt_vld=0 during and after reset.
2. Single packet: src_vld[3]=1, dst3=1, 3-beat packet, tgt_rdy=3'b111.
   - Cycle+1: src_req slice3=3'b010, tgt_vld[1]=1.
   - Beats pass with src_rdy[3]=1.
   - src_req=0 the cycle after last.
3. Contention: sources 0, 2 and 4 all dst=0 with 1-beat packets and ptr=0.
   - Grants follow order 0, 2, 4, then return to 0 if the request is re-asserted.
   - Without B2B: a 1-cycle gap between grants.
   - With RSP_XARB_B2B_EN: no gap.
4. Parallel routing: source 1 dst=0, source 3 dst=2 in the same cycle -> both granted next cycle, src_req slice1=3'b001, slice3=3'b100, and no shared bits.
5. Backpressure and bubble on target 2, owner source 4:
   - tgt_rdy[2]=0 for 4 cycles -> src_rdy[4]=0 and the grant is held.
   - src_vld[4] deasserted -> tgt_vld[2]=0 and the grant is held.
6. Out-of-range index and reset mid-packet:
   - dst=3 -> never granted, src_rdy stays 0.
   - rst asserted during beat 2 of a packet -> src_req=0 asynchronously, and ptrs=0 after reset.
